jtsdram_bank_check: RTL and testbench

- Read-checker for one SDRAM bank in the SDRAM self-test.
- On a start pulse it sweeps a linear address range, issuing one read per address through the bank's rd/ack/rdy handshake.
- Each returned word is compared against the expected word supplied by the external address-shuffle/reference block.
- Reports a sticky mismatch flag and a sweep-complete flag to the test sequencer.

---
 rtl/jtsdram_bank_check.sv | 98 +++++++++
 tb/tb_jtsdram_bank_check.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsdram_bank_check.sv
// Read-checker for one SDRAM bank: sweeps 0..LAST_ADDR, one read in flight at a time, and
// compares each returned word with the reference word for the current address.
module jtsdram_bank_check #(
  parameter logic [21:0] LAST_ADDR = 22'h3F_FFFF,
  parameter logic [21:0] STEP      = 22'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LVBL,
  input  logic        start,
  output logic [21:0] addr,
  output logic        rd,
  input  logic        ack,
  input  logic        rdy,
  input  logic [31:0] data_read,
  input  logic [15:0] data_ref,
  output logic        bad,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StNext} state_e;

  state_e      state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        bad_q, bad_d;
  logic        done_q, done_d;

  // Upper half of the read bus carries no checked data.
  logic unused_data_hi;
  assign unused_data_hi = ^data_read[31:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    bad_d   = bad_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          done_d  = 1'b0;
          state_d = StNext;
        end
      end
      // Also gives data_ref a cycle to settle after the address moves.
      StNext: begin
        if (LVBL) begin
          rd_d    = 1'b1;
          state_d = StReq;
        end
      end
      // rd stays up until accepted; a rdy here is not ours and is ignored.
      StReq: begin
        if (ack) begin
          rd_d    = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (rdy) begin
          if (data_read[15:0] != data_ref) bad_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + STEP;
            state_d = StNext;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr = addr_q;
  assign rd   = rd_q;
  assign bad  = bad_q;
  assign done = done_q;

endmodule

// File: tb/tb_jtsdram_bank_check.sv
// Bench for jtsdram_bank_check: a small controller model answers reads, and a scoreboard
// queue holds the address sequence each sweep must request.
module tb_jtsdram_bank_check;

  localparam logic [21:0] LAST = 22'd7;

  logic        clk = 1'b0;
  logic        rst, LVBL, start;
  logic [21:0] addr;
  logic        rd, ack, rdy, bad, done;
  logic [31:0] data_read;
  logic [15:0] data_ref;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd     = 0;

  logic [21:0] sb_q[$];

  // Controller model knobs
  int          ack_delay   = 2;
  int          rdy_delay   = 3;
  logic        spurious    = 1'b0;
  logic        corrupt_en  = 1'b0;
  logic [21:0] corrupt_addr = '0;
  logic        abort       = 1'b0;
  logic        in_wait     = 1'b0;
  logic        exp_bad     = 1'b0;

  jtsdram_bank_check #(
    .LAST_ADDR (LAST),
    .STEP      (22'd1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .LVBL      (LVBL),
    .start     (start),
    .addr      (addr),
    .rd        (rd),
    .ack       (ack),
    .rdy       (rdy),
    .data_read (data_read),
    .data_ref  (data_ref),
    .bad       (bad),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference pattern produced by the external shuffle block.
  assign data_ref = (addr[15:0] * 16'h9E37) ^ 16'hA5C3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: acts on falling edges so the DUT samples stable inputs.
  initial begin : ctrl_model
    logic [21:0] req_addr;
    logic [21:0] exp_addr;
    ack = 1'b0;
    rdy = 1'b0;
    data_read = '0;
    forever begin
      @(negedge clk);
      if (rd && !rst) begin
        req_addr = addr;
        n_rd++;
        exp_addr = (sb_q.size() != 0) ? sb_q.pop_front() : ~addr;
        check("rd addr", addr, exp_addr);
        for (int i = 1; i < ack_delay; i++) begin
          @(negedge clk);
          if (rdy) begin
            rdy = 1'b0;
            check("bad after spurious rdy", bad, exp_bad);
            check("addr after spurious rdy", addr, req_addr);
          end
          check("rd held until ack", rd, 1);
          if (spurious && i == 1) begin
            rdy = 1'b1;
            data_read = {16'hBEEF, ~data_ref};
          end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("rd drops after ack", rd, 0);
        in_wait = 1'b1;
        repeat (rdy_delay - 1) @(negedge clk);
        in_wait = 1'b0;
        if (abort) begin
          data_read = {16'hBEEF, ~data_ref};
        end else if (corrupt_en && addr == corrupt_addr) begin
          data_read = {16'hBEEF, data_ref ^ 16'h0001};
          exp_bad = 1'b1;
        end else begin
          data_read = {16'hBEEF, data_ref};
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        if (abort) abort = 1'b0;
        else check("bad after rdy", bad, exp_bad);
      end
    end
  end

  task automatic push_sweep();
    for (int a = 0; a <= int'(LAST); a++) sb_q.push_back(22'(a));
  endtask

  task automatic pulse_start(input logic accept);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (accept) check("done clears on start", done, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, " done"}, done, 1);
    check({tag, " rd idle"}, rd, 0);
    check({tag, " final addr"}, addr, LAST);
    check({tag, " all reads issued"}, sb_q.size(), 0);
  endtask

  task automatic wait_addr(input logic [21:0] a, input logic need_wait);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (addr == a && (!need_wait || in_wait)) break;
    end
    check("reached addr", addr, a);
  endtask

  initial begin : stim
    int n0;
    rst = 1'b1;
    LVBL = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset addr", addr, 0);
    check("reset rd", rd, 0);
    check("reset bad", bad, 0);
    check("reset done", done, 0);
    rst = 1'b0;

    // 1: clean sweep
    push_sweep();
    n0 = n_rd;
    pulse_start(1'b1);
    wait_done("t1");
    check("t1 bad", bad, 0);
    check("t1 read count", n_rd - n0, 8);
    repeat (3) @(negedge clk);
    check("t1 rd stays low", rd, 0);

    // 2: one corrupted word, then a clean re-sweep
    corrupt_en = 1'b1;
    corrupt_addr = 22'd5;
    push_sweep();
    pulse_start(1'b1);
    wait_done("t2a");
    check("t2 bad set", bad, 1);
    corrupt_en = 1'b0;
    push_sweep();
    pulse_start(1'b1);
    wait_done("t2b");
    check("t2 bad sticky", bad, 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_bad = 1'b0;
    check("bad cleared by rst", bad, 0);

    // 3: blanking holds off new reads but never drops an outstanding one
    LVBL = 1'b0;
    push_sweep();
    pulse_start(1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3 no rd in blank", rd, 0);
      check("t3 addr in blank", addr, 0);
    end
    ack_delay = 4;
    LVBL = 1'b1;
    @(negedge clk);
    check("t3 rd after LVBL", rd, 1);
    LVBL = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t3 rd held in blank", rd, 1);
    end
    repeat (10) @(negedge clk);
    check("t3 stalled addr", addr, 1);
    ack_delay = 2;
    LVBL = 1'b1;
    wait_done("t3");

    // 4: slow ack with a stray rdy during the request phase
    ack_delay = 20;
    spurious = 1'b1;
    push_sweep();
    pulse_start(1'b1);
    wait_done("t4");
    check("t4 bad", bad, 0);
    ack_delay = 2;
    spurious = 1'b0;

    // 5: reset while waiting for data at addr 3
    corrupt_en = 1'b1;
    corrupt_addr = 22'd1;
    push_sweep();
    pulse_start(1'b1);
    wait_addr(22'd3, 1'b1);
    check("t5 bad before rst", bad, 1);
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_bad = 1'b0;
    sb_q.delete();
    check("t5 addr", addr, 0);
    check("t5 rd", rd, 0);
    check("t5 done", done, 0);
    check("t5 bad", bad, 0);
    repeat (6) @(negedge clk);
    check("t5 late rdy bad", bad, 0);
    check("t5 late rdy addr", addr, 0);
    check("t5 late rdy done", done, 0);
    corrupt_en = 1'b0;
    push_sweep();
    pulse_start(1'b1);
    wait_done("t5");
    check("t5 bad after sweep", bad, 0);

    // 6: start mid-sweep is ignored; start after done re-runs
    push_sweep();
    pulse_start(1'b1);
    wait_addr(22'd4, 1'b0);
    pulse_start(1'b0);
    wait_done("t6a");
    push_sweep();
    pulse_start(1'b1);
    wait_done("t6b");
    check("t6 bad", bad, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
